nn_output_neuron: RTL and testbench
===================================

NN_OUTPUT_NEURON -- requirements
Module: nn_output_neuron

Interface
REQ-001 Parameter N_IN, default 2, number of upstream hidden-layer activations consumed (1..8).
REQ-002 Parameter FRAC, default 4, fractional bits of the signed Q(8-FRAC).FRAC data format.
REQ-003 Parameter W_INIT, default {8'sd20, -8'sd12}, packed signed 8-bit weights; lane i occupies bits [8i+7:8i].
REQ-004 Parameter B_INIT, default 8'sd4, signed 8-bit bias.
REQ-005 Parameter ACT, default 0: 0 = identity, 1 = ReLU, 2 = hard sigmoid.
REQ-006 clk  input  1  clock; all state changes on posedge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 ack_in  input  N_IN  per-lane acknowledge from upstream neurons; a level that may stay high indefinitely.
REQ-009 a_in  input  8*N_IN  packed signed activations; lane i is valid while ack_in[i] is high.
REQ-010 y  output  8  signed result in the same Q format.
REQ-011 ack_out  output  1  result-valid level.
REQ-012 busy  output  1  high in any state other than IDLE and DONE.

Function
REQ-013 The block SHALL register ack_in each cycle and SHALL treat a 0->1 transition of ack_in[i] versus that registered copy as a lane event.
REQ-014 The FSM SHALL have the states IDLE, COLLECT, MAC, BIAS, ACT and DONE.
REQ-015 IDLE/DONE -> COLLECT on any lane event:
- the block SHALL clear all captured flags;
- it SHALL capture the event lanes;
- it SHALL drop ack_out on the same edge.
REQ-016 In COLLECT, a lane event SHALL capture a_in[i] into the lane register and set captured[i]; a repeat event on a lane that is already captured SHALL overwrite its value (latest value wins).
REQ-017 Simultaneous events on several lanes in one cycle SHALL all be captured on that edge.
REQ-018 COLLECT -> MAC on the edge after all captured bits are set; the accumulator SHALL clear to 0 on entry.
REQ-019 MAC SHALL process one lane per cycle, in order from lane 0 to lane N_IN-1, for exactly N_IN cycles:
- the product SHALL be the signed 16-bit value a*w;
- it SHALL be arithmetic-shifted right by FRAC (floor);
- it SHALL be sign-extended and added into a signed 16-bit accumulator.
REQ-020 BIAS SHALL add the sign-extended B_INIT to the accumulator in 1 cycle.
REQ-021 ACT SHALL complete in 1 cycle and write y:
- ACT 0: s = the accumulator saturated to [-128,127];
- ACT 1: max(0, s);
- ACT 2: clamp((acc>>>2) + (1<<(FRAC-1)), 0, 1<<FRAC).
REQ-022 ACT -> DONE SHALL set ack_out=1; y and ack_out SHALL hold in DONE until rst or a new lane event.
REQ-023 Latency SHALL be as follows: if the last missing lane is captured on edge k, ack_out is high after edge k+N_IN+3.
REQ-024 Lane events during MAC, BIAS or ACT SHALL be ignored, and the captured values SHALL be unchanged.
REQ-025 Upstream acks that stay high forever SHALL yield exactly one result per rising edge, with no retrigger.
REQ-026 Weights and bias SHALL be constants held in internal ROM/registers initialised from the parameters.

Reset
REQ-027 On rst, on the next posedge, the block SHALL enter IDLE and drive y=0, ack_out=0 and busy=0.
REQ-028 On rst, on the next posedge, the block SHALL clear the captured flags, the accumulator and the registered ack_in.
REQ-029 rst asserted in any state, including mid-MAC, SHALL abort the computation with no ack_out pulse.
REQ-030 After rst deasserts, an ack_in that is already high SHALL count as a lane event on the first non-reset cycle.

Verification
REQ-031 Lanes both 16 (1.0), with both ack_in rising together, ACT=0 -> y=12 and ack_out high 5 edges later.
REQ-032 Same stimulus with ACT=1 -> y=12; with ACT=2 -> y=11.
REQ-033 Lane0 ack rises with a=16, then 3 cycles later lane1 ack rises with a=16 -> busy stays high in COLLECT and y=12 after lane1 capture +5 edges; lane1 re-acked in COLLECT with a=32 before lane0 arrives -> y=0.
REQ-034 W_INIT={127,127}, B_INIT=127, a={127,127} -> accumulator 2143, y saturates to 127; W={-1,0}, a={1,0}, B=0 -> y=-1 (floor shift).
REQ-035 rst asserted during the second MAC cycle -> ack_out stays 0 and y=0; after release, held-high acks restart the round and produce y=12.
REQ-036 In DONE, ack_in dropped then lane0 re-raised -> ack_out falls on that edge and a new COLLECT begins with only lane0 captured.

Source files
------------

// File: rtl/nn_output_neuron.sv
// nn_output_neuron
//   Output-layer neuron. It collects one signed Q(8-FRAC).FRAC activation per
//   upstream lane, using the rising edge of each lane's ack level to trigger
//   the capture. It then multiplies each lane by a constant weight, adds a
//   constant bias, applies the selected activation and presents the result
//   together with a valid level.
//
// Ports
//   clk      clock; all state changes on posedge
//   rst      synchronous, active-high reset
//   ack_in   [N_IN]    per-lane acknowledge level from upstream neurons
//   a_in     [8*N_IN]  packed signed activations, lane i at [8i+7:8i]
//   y        [8]       signed result, same Q format as the inputs
//   ack_out            result-valid level, held until the next round starts
//   busy               high while a round is in progress (not IDLE/DONE)
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no result yet, waiting for the first lane event
// COLLECT | capturing lanes until every captured flag is set
// MAC     | one lane per cycle: acc += (a*w) >>> FRAC
// BIAS    | acc += bias
// ACT     | apply the activation function and write y
// DONE    | y and ack_out held until a new lane event

module nn_output_neuron #(
    parameter int                 N_IN   = 2,
    parameter int                 FRAC   = 4,
    parameter logic [8*N_IN-1:0]  W_INIT = {8'sd20, -8'sd12},
    parameter logic signed [7:0]  B_INIT = 8'sd4,
    parameter int                 ACT    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_IN-1:0]     ack_in,
    input  logic [8*N_IN-1:0]   a_in,
    output logic signed [7:0]   y,
    output logic                ack_out,
    output logic                busy
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_MAC     = 3'd2;
    localparam logic [2:0] S_BIAS    = 3'd3;
    localparam logic [2:0] S_ACT     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic signed [15:0] BIAS_EXT = {{8{B_INIT[7]}}, B_INIT};
    localparam logic signed [15:0] SAT_HI   = 16'sd127;
    localparam logic signed [15:0] SAT_LO   = -16'sd128;
    localparam logic signed [15:0] HS_HALF  = 16'(1 << (FRAC - 1));
    localparam logic signed [15:0] HS_ONE   = 16'(1 << FRAC);

    logic [2:0]              state;
    logic [N_IN-1:0]         ack_q;
    logic [N_IN-1:0]         captured;
    logic [N_IN-1:0]         ev;
    logic [IW-1:0]           lane_idx;
    logic signed [15:0]      acc;
    logic signed [7:0]       lane_val [N_IN];
    logic signed [7:0]       w_rom    [N_IN];
    logic                    cap_en;

    logic signed [15:0]      a_ext;
    logic signed [15:0]      w_ext;
    logic signed [15:0]      prod;
    logic signed [15:0]      mac_term;
    logic signed [15:0]      sat_val;
    logic signed [15:0]      hs_val;
    logic signed [7:0]       act_val;

    // Weights are fixed at elaboration; this is the constant weight ROM.
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_wrom
        assign w_rom[gi] = W_INIT[8*gi +: 8];
    end

    assign ev   = ack_in & ~ack_q;
    assign busy = (state != S_IDLE) && (state != S_DONE);

    // Lanes are captured on the round-starting edge and during COLLECT until
    // every lane has been seen. The COLLECT->MAC edge captures nothing, so
    // late events cannot disturb the values being multiplied.
    assign cap_en = (state == S_IDLE) || (state == S_DONE) ||
                    ((state == S_COLLECT) && !(&captured));

    always_comb begin
        a_ext    = {{8{lane_val[lane_idx][7]}}, lane_val[lane_idx]};
        w_ext    = {{8{w_rom[lane_idx][7]}}, w_rom[lane_idx]};
        prod     = a_ext * w_ext;
        mac_term = prod >>> FRAC;
    end

    always_comb begin
        sat_val = acc;
        if (acc > SAT_HI) begin
            sat_val = SAT_HI;
        end else if (acc < SAT_LO) begin
            sat_val = SAT_LO;
        end

        // The hard sigmoid works from the raw accumulator, not the
        // saturated value, so large inputs clamp to exactly 1.0.
        hs_val = (acc >>> 2) + HS_HALF;
        if (hs_val < 16'sd0) begin
            hs_val = 16'sd0;
        end else if (hs_val > HS_ONE) begin
            hs_val = HS_ONE;
        end

        act_val = sat_val[7:0];
        if (ACT == 1) begin
            act_val = (sat_val < 16'sd0) ? 8'sd0 : sat_val[7:0];
        end else if (ACT == 2) begin
            act_val = hs_val[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int i = 0; i < N_IN; i++) begin
                if (ev[i]) begin
                    lane_val[i] <= a_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            ack_q    <= '0;
            captured <= '0;
            lane_idx <= '0;
            acc      <= '0;
            y        <= '0;
            ack_out  <= 1'b0;
        end else begin
            ack_q <= ack_in;
            case (state)
                S_IDLE, S_DONE: begin
                    if (|ev) begin
                        captured <= ev;
                        ack_out  <= 1'b0;
                        state    <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (&captured) begin
                        acc      <= '0;
                        lane_idx <= '0;
                        state    <= S_MAC;
                    end else begin
                        captured <= captured | ev;
                    end
                end
                S_MAC: begin
                    acc      <= acc + mac_term;
                    lane_idx <= lane_idx + IW'(1);
                    if (lane_idx == IW'(N_IN - 1)) begin
                        state <= S_BIAS;
                    end
                end
                S_BIAS: begin
                    acc   <= acc + BIAS_EXT;
                    state <= S_ACT;
                end
                S_ACT: begin
                    y       <= act_val;
                    ack_out <= 1'b1;
                    state   <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_output_neuron.sv
// Testbench for nn_output_neuron. Five instances share the same stimulus:
// the default neuron with ACT 0/1/2, a saturating variant (weights 127, bias
// 127) and a floor-shift variant (weights {-1,0}, bias 0).
module tb_nn_output_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ack_in;
    logic [15:0] a_in;

    logic signed [7:0] y0, y1, y2, ys, yn;
    logic ack0, ack1, ack2, acks, ackn;
    logic busy0, busy1, busy2, busys, busyn;

    always #5 clk = ~clk;

    nn_output_neuron #(.ACT(0)) dut0 (
        .clk(clk), .rst(rst), .ack_in(ack_in), .a_in(a_in),
        .y(y0), .ack_out(ack0), .busy(busy0));
    nn_output_neuron #(.ACT(1)) dut1 (
        .clk(clk), .rst(rst), .ack_in(ack_in), .a_in(a_in),
        .y(y1), .ack_out(ack1), .busy(busy1));
    nn_output_neuron #(.ACT(2)) dut2 (
        .clk(clk), .rst(rst), .ack_in(ack_in), .a_in(a_in),
        .y(y2), .ack_out(ack2), .busy(busy2));
    nn_output_neuron #(.W_INIT({8'sd127, 8'sd127}), .B_INIT(8'sd127), .ACT(0)) dut_s (
        .clk(clk), .rst(rst), .ack_in(ack_in), .a_in(a_in),
        .y(ys), .ack_out(acks), .busy(busys));
    nn_output_neuron #(.W_INIT({-8'sd1, 8'sd0}), .B_INIT(8'sd0), .ACT(0)) dut_n (
        .clk(clk), .rst(rst), .ack_in(ack_in), .a_in(a_in),
        .y(yn), .ack_out(ackn), .busy(busyn));

    typedef struct {
        int a0;
        int a1;
        int gap;
        int y0;
        int y2;
    } vec_t;

    typedef struct {
        int y0;
        int y1;
        int y2;
        int ys;
        int yn;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ack0_prev = 1'b0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference: two lanes, floor-shifted products, bias, then activation.
    function automatic int model(input int a0, input int a1, input int w0,
                                 input int w1, input int b, input int act);
        int acc;
        int s;
        int h;
        acc = ((a0 * w0) >>> 4) + ((a1 * w1) >>> 4) + b;
        s = (acc > 127) ? 127 : ((acc < -128) ? -128 : acc);
        if (act == 1) return (s < 0) ? 0 : s;
        if (act == 2) begin
            h = (acc >>> 2) + 8;
            return (h < 0) ? 0 : ((h > 16) ? 16 : h);
        end
        return s;
    endfunction

    task automatic push(input int a0, input int a1, input int e0, input int e2);
        exp_t e;
        e.y0 = e0;
        e.y2 = e2;
        e.y1 = model(a0, a1, -12, 20, 4, 1);
        e.ys = model(a0, a1, 127, 127, 127, 0);
        e.yn = model(a0, a1, 0, -1, 0, 0);
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (ack0 !== 1'b1 && n < 30);
    endtask

    // Scoreboard: each rising ack_out consumes one expected result.
    always @(negedge clk) begin
        if (ack0 && !ack0_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got y=%0d expected no result", y0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("y_act0", int'(y0), e.y0);
                chk("y_act1", int'(y1), e.y1);
                chk("y_act2", int'(y2), e.y2);
                chk("y_sat",  int'(ys), e.ys);
                chk("y_floor", int'(yn), e.yn);
                chk("acks_aligned", int'(ack1 & ack2 & acks & ackn), 1);
            end
        end
        ack0_prev = ack0;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    vec_t vecs[10];
    int   n;

    initial begin
        vecs[0] = '{16,   16,   0, 12,   11};
        vecs[1] = '{16,   16,   3, 12,   11};
        vecs[2] = '{-16,  16,   0, 36,   16};
        vecs[3] = '{32,   -32,  1, -60,  0};
        vecs[4] = '{127,  127,  0, 66,   16};
        vecs[5] = '{0,    100,  2, 127,  16};
        vecs[6] = '{1,    0,    0, 3,    8};
        vecs[7] = '{0,    1,    1, 5,    9};
        vecs[8] = '{16,   0,    0, -8,   6};
        vecs[9] = '{127,  -128, 0, -128, 0};

        rst = 1'b1;
        ack_in = '0;
        a_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_y", int'(y0), 0);
        chk("rst_ack_out", int'(ack0), 0);
        chk("rst_busy", int'(busy0), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk) ack_in = '0;
            @(negedge clk);
            a_in[7:0] = 8'(vecs[i].a0);
            ack_in[0] = 1'b1;
            if (vecs[i].gap == 0) begin
                a_in[15:8] = 8'(vecs[i].a1);
                ack_in[1] = 1'b1;
            end else begin
                repeat (vecs[i].gap) @(negedge clk);
                chk("collect_busy", int'(busy0), 1);
                chk("collect_no_ack", int'(ack0), 0);
                a_in[15:8] = 8'(vecs[i].a1);
                ack_in[1] = 1'b1;
            end
            push(vecs[i].a0, vecs[i].a1, vecs[i].y0, vecs[i].y2);
            wait_ack(0, n);
            chk("latency", n, 6);
        end

        // Lane1 first, then re-acked with a new value (latest wins).
        @(negedge clk) ack_in = '0;
        @(negedge clk) a_in[15:8] = 8'd16; ack_in = 2'b10;
        @(negedge clk) ack_in = 2'b00;
        @(negedge clk) a_in[15:8] = 8'd32; ack_in = 2'b10;
        @(negedge clk);
        chk("reack_busy", int'(busy0), 1);
        chk("reack_no_ack", int'(ack0), 0);
        a_in[7:0] = 8'd58;
        ack_in = 2'b11;
        push(58, 32, 0, 8);
        wait_ack(0, n);
        chk("reack_latency", n, 6);

        // Events during MAC are ignored; held-high acks do not retrigger.
        @(negedge clk) ack_in = '0;
        @(negedge clk) a_in = {8'd16, 8'd16}; ack_in = 2'b11;
        push(16, 16, 12, 11);
        @(negedge clk);
        @(negedge clk) ack_in = 2'b00; a_in = {8'd100, 8'd100};
        @(negedge clk) ack_in = 2'b11;
        wait_ack(3, n);
        chk("mac_ignore_latency", n, 6);
        repeat (5) @(negedge clk);
        chk("no_retrigger_ack", int'(ack0), 1);
        chk("no_retrigger_busy", int'(busy0), 0);
        chk("hold_y", int'(y0), 12);

        // Reset during the second MAC cycle aborts; held acks restart.
        @(negedge clk) ack_in = '0;
        @(negedge clk) a_in = {8'd16, 8'd16}; ack_in = 2'b11;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("abort_ack", int'(ack0), 0);
        chk("abort_y", int'(y0), 0);
        chk("abort_busy", int'(busy0), 0);
        @(negedge clk);
        chk("abort_ack_hold", int'(ack0), 0);
        rst = 1'b0;
        push(16, 16, 12, 11);
        wait_ack(0, n);
        chk("restart_latency", n, 6);

        // In DONE: drop acks, re-raise lane0 only.
        @(negedge clk) ack_in = '0;
        @(negedge clk) a_in[7:0] = 8'd32; ack_in = 2'b01;
        @(negedge clk);
        chk("done_drop_ack", int'(ack0), 0);
        chk("done_drop_busy", int'(busy0), 1);
        repeat (4) @(negedge clk);
        chk("lane0_only_ack", int'(ack0), 0);
        chk("lane0_only_busy", int'(busy0), 1);
        a_in[15:8] = 8'd48;
        ack_in = 2'b11;
        push(32, 48, 40, 16);
        wait_ack(0, n);
        chk("lane0_only_latency", n, 6);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
